// File: rtl/dram_timing_ctrl.sv
// dram_timing_ctrl: command-timing engine for the DRAM controller.
// Counts timing windows after each issued command and returns single-cycle
// completion strobes, the refresh request and the read/write burst windows.
module dram_timing_ctrl #(
  parameter int unsigned T_RCD     = 14,
  parameter int unsigned T_RAS     = 32,
  parameter int unsigned T_RP      = 14,
  parameter int unsigned T_RFC     = 280,
  parameter int unsigned T_CL      = 16,
  parameter int unsigned T_CWL     = 12,
  parameter int unsigned BURST_CYC = 4,
  parameter int unsigned T_WR      = 16,
  parameter int unsigned T_WTR     = 8,
  parameter int unsigned T_REFI    = 7800,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       cmd_issue,
  input  logic [2:0] cmd,
  output logic       tACT_done,
  output logic       tRAS_done,
  output logic       tPRE_done,
  output logic       tREF_done,
  output logic       tRD_done,
  output logic       tWRITE_done,
  output logic       tWR_done,
  output logic       tWTR_done,
  output logic       rf_req,
  output logic       rd_en,
  output logic       wr_en,
  output logic       clear
);

  typedef enum logic [2:0] {
    IDLE,
    ACT_W,
    RD_W,
    WR_W,
    PRE_W,
    REF_W
  } state_t;

  // Terminal counts are stored one below the target cycle because the
  // counter value seen at an edge is the count before that edge.
  localparam int unsigned PW_MAX = (T_WR > T_WTR) ? T_WR : T_WTR;

  localparam logic [CNT_W-1:0] RCD_TC  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_TC   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_TC  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] RD_ON   = CNT_W'(T_CL - 1);
  localparam logic [CNT_W-1:0] RD_OFF  = CNT_W'(T_CL + BURST_CYC - 2);
  localparam logic [CNT_W-1:0] RD_TC   = CNT_W'(T_CL + BURST_CYC - 1);
  localparam logic [CNT_W-1:0] WR_ON   = CNT_W'(T_CWL - 1);
  localparam logic [CNT_W-1:0] WR_OFF  = CNT_W'(T_CWL + BURST_CYC - 2);
  localparam logic [CNT_W-1:0] WRB_TC  = CNT_W'(T_CWL + BURST_CYC - 1);
  localparam logic [CNT_W-1:0] RAS_TC  = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] WR_TC   = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] WTR_TC  = CNT_W'(T_WTR - 1);
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PW_MAX - 1);
  localparam logic [CNT_W-1:0] REFI_TC = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  state_t           issue_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_active;
  logic [CNT_W-1:0] pw_cnt;
  logic             pw_active;
  logic [CNT_W-1:0] ref_cnt;
  logic             new_cmd;
  logic             act_issue;
  logic             pre_issue;
  logic             ref_issue;
  logic             wr_term;

  // Command decode: codes 6/7 and NOP never start or abort a window.
  always_comb begin
    issue_state = IDLE;
    case (cmd)
      3'd1:    issue_state = ACT_W;
      3'd2:    issue_state = RD_W;
      3'd3:    issue_state = WR_W;
      3'd4:    issue_state = PRE_W;
      3'd5:    issue_state = REF_W;
      default: issue_state = IDLE;
    endcase
  end

  assign new_cmd   = cmd_issue && (issue_state != IDLE);
  assign act_issue = cmd_issue && (cmd == 3'd1);
  assign pre_issue = cmd_issue && (cmd == 3'd4);
  assign ref_issue = cmd_issue && (cmd == 3'd5);

  // A new command landing on the write terminal edge aborts the write, so
  // the post-write counter must not start on that edge either.
  assign wr_term = (state == WR_W) && (cnt == WRB_TC) && !new_cmd;

  // Main window FSM: loads on any issue, strobes and idles at terminal count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      tACT_done   <= 1'b0;
      tPRE_done   <= 1'b0;
      tREF_done   <= 1'b0;
      tRD_done    <= 1'b0;
      tWRITE_done <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
    end else begin
      tACT_done   <= 1'b0;
      tPRE_done   <= 1'b0;
      tREF_done   <= 1'b0;
      tRD_done    <= 1'b0;
      tWRITE_done <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      if (new_cmd) begin
        state <= issue_state;
        cnt   <= '0;
      end else begin
        case (state)
          ACT_W: begin
            if (cnt == RCD_TC) begin
              tACT_done <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          PRE_W: begin
            if (cnt == RP_TC) begin
              tPRE_done <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          REF_W: begin
            if (cnt == RFC_TC) begin
              tREF_done <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          RD_W: begin
            rd_en <= (cnt >= RD_ON) && (cnt <= RD_OFF);
            if (cnt == RD_TC) begin
              tRD_done <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          WR_W: begin
            wr_en <= (cnt >= WR_ON) && (cnt <= WR_OFF);
            if (cnt == WRB_TC) begin
              tWRITE_done <= 1'b1;
              state       <= IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // RAS window: ACT (re)starts it, PRE cancels it silently.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ras_active <= 1'b0;
      ras_cnt    <= '0;
      tRAS_done  <= 1'b0;
    end else begin
      tRAS_done <= 1'b0;
      if (act_issue) begin
        ras_active <= 1'b1;
        ras_cnt    <= '0;
      end else if (pre_issue) begin
        ras_active <= 1'b0;
      end else if (ras_active) begin
        if (ras_cnt == RAS_TC) begin
          tRAS_done  <= 1'b1;
          ras_active <= 1'b0;
        end else begin
          ras_cnt <= ras_cnt + ONE;
        end
      end
    end
  end

  // Post-write recovery: counts from the tWRITE_done edge, independent of REF.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pw_active <= 1'b0;
      pw_cnt    <= '0;
      tWR_done  <= 1'b0;
      tWTR_done <= 1'b0;
    end else begin
      tWR_done  <= 1'b0;
      tWTR_done <= 1'b0;
      if (wr_term) begin
        pw_active <= 1'b1;
        pw_cnt    <= '0;
      end else if (pw_active) begin
        if (pw_cnt == WTR_TC) tWTR_done <= 1'b1;
        if (pw_cnt == WR_TC) tWR_done <= 1'b1;
        if (pw_cnt == PW_LAST) begin
          pw_active <= 1'b0;
        end else begin
          pw_cnt <= pw_cnt + ONE;
        end
      end
    end
  end

  // Refresh interval: free-running, saturating, cleared by any REF issue.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ref_cnt <= '0;
    end else if (ref_issue) begin
      ref_cnt <= '0;
    end else if (ref_cnt != REFI_TC) begin
      ref_cnt <= ref_cnt + ONE;
    end
  end

  assign rf_req = (ref_cnt == REFI_TC);

  assign clear = tACT_done | tRAS_done | tPRE_done | tREF_done |
                 tRD_done | tWRITE_done | tWR_done | tWTR_done;

endmodule
